seq_fsm_table: RTL and testbench

//  Table-driven, run-time programmable Moore sequencer: generalises the fixed 3-bit, 1-input state machines.

---
 rtl/seq_fsm_table_if.sv | 32 +++
 rtl/seq_fsm_table.sv | 118 +++++++++++
 tb/tb_seq_fsm_table.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_fsm_table_if.sv
// Control/table-write/status bundle for the table-driven sequencer.
// Pure wiring: no storage, no latency.
// No backpressure: the sequencer accepts a step and a table write on every edge.
interface seq_fsm_table_if #(
    parameter int SW   = 3,
    parameter int CW   = 1,
    parameter int OW   = 3,
    parameter int CNTW = 8
);
    logic              en;
    logic              restart;
    logic [CW-1:0]     a;
    logic              wr_en;
    logic [SW+CW-1:0]  wr_addr;
    logic [SW+OW-1:0]  wr_data;
    logic [OW-1:0]     s;
    logic [SW-1:0]     state;
    logic              mark;
    logic [CNTW-1:0]   cycle_cnt;

    // Stimulus/control side
    modport master (
        output en, restart, a, wr_en, wr_addr, wr_data,
        input  s, state, mark, cycle_cnt
    );

    // Sequencer side
    modport slave (
        input  en, restart, a, wr_en, wr_addr, wr_data,
        output s, state, mark, cycle_cnt
    );
endinterface

// File: rtl/seq_fsm_table.sv
// Run-time programmable Moore sequencer: {a, state} indexes a {next_state, out} table.
// Latency: one edge from a/state to registered s, state and mark.
// No backpressure: en=0 holds the machine; table writes are accepted every edge.
// Optional completed-cycle counter enabled by macro SEQ_FSM_CYCLE_CNT_EN.
module seq_fsm_table #(
    parameter int SW    = 3,
    parameter int CW    = 1,
    parameter int OW    = 3,
    parameter int START = 0,
    parameter int MARK  = 2,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    seq_fsm_table_if.slave     bus
);
    localparam int AW    = SW + CW;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = SW + OW;

    localparam logic [SW-1:0] START_S   = SW'(START);
    localparam logic [SW-1:0] MARK_S    = SW'(MARK);
    localparam logic [EW-1:0] RST_ENTRY = {START_S, {OW{1'b0}}};

    logic [EW-1:0] table_q [DEPTH];
    logic [EW-1:0] table_d [DEPTH];
    logic [SW-1:0] state_q, state_d;
    logic [OW-1:0] s_q, s_d;
    logic          mark_q, mark_d;

    logic [AW-1:0] rd_addr;
    logic [SW-1:0] ent_next;
    logic [OW-1:0] ent_out;

    // Table lookup: reads the registered contents, so a same-edge write is not yet visible
    always_comb begin
        rd_addr             = {bus.a, state_q};
        {ent_next, ent_out} = table_q[rd_addr];
    end

    // Next-state/output: restart beats en; idle edges hold state and s but drop mark
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        mark_d  = 1'b0;
        if (bus.restart) begin
            state_d = START_S;
            s_d     = '0;
        end else if (bus.en) begin
            state_d = ent_next;
            s_d     = ent_out;
            mark_d  = (ent_next == MARK_S);
        end
    end

    // Table write port, independent of en/restart
    always_comb begin
        table_d = table_q;
        if (bus.wr_en) begin
            table_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= START_S;
            s_q     <= '0;
            mark_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            mark_q  <= mark_d;
        end
    end

    // Table storage; reset parks every entry at {START, 0}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RST_ENTRY;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

`ifdef SEQ_FSM_CYCLE_CNT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Count edges that raise mark, saturating at all-ones; restart does not clear it
    always_comb begin
        cnt_d = cnt_q;
        if (mark_d && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cycle_cnt = cnt_q;
`else
    assign bus.cycle_cnt = '0;
`endif

    assign bus.s     = s_q;
    assign bus.state = state_q;
    assign bus.mark  = mark_q;
endmodule

// File: tb/tb_seq_fsm_table.sv
// Bench for seq_fsm_table: directed scenarios plus a randomized phase against a table model.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
// Counter expectations follow SEQ_FSM_CYCLE_CNT_EN (zero when the macro is undefined).
module tb_seq_fsm_table;
    localparam int SW    = 3;
    localparam int CW    = 1;
    localparam int OW    = 3;
    localparam int START = 0;
    localparam int MARK  = 2;
    localparam int CNTW  = 2;
    localparam int DEPTH = 1 << (SW + CW);
    localparam int CMAX  = (1 << CNTW) - 1;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    seq_fsm_table_if #(.SW(SW), .CW(CW), .OW(OW), .CNTW(CNTW)) bus ();

    seq_fsm_table #(
        .SW(SW), .CW(CW), .OW(OW), .START(START), .MARK(MARK), .CNTW(CNTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: table of (next, out) pairs plus the observable registers
    int m_next [DEPTH];
    int m_out  [DEPTH];
    int m_state, m_s, m_mark, m_cnt;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_next[i] = START;
            m_out[i]  = 0;
        end
        m_state = START;
        m_s     = 0;
        m_mark  = 0;
        m_cnt   = 0;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently driven
    task automatic model_edge();
        int idx, nxt, out;
        idx = int'(bus.a) * (1 << SW) + m_state;
        nxt = m_next[idx];
        out = m_out[idx];
        if (bus.restart) begin
            m_state = START;
            m_s     = 0;
            m_mark  = 0;
        end else if (bus.en) begin
            m_state = nxt;
            m_s     = out;
            m_mark  = (nxt == MARK) ? 1 : 0;
        end else begin
            m_mark = 0;
        end
`ifdef SEQ_FSM_CYCLE_CNT_EN
        if (m_mark == 1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
`endif
        if (bus.wr_en) begin
            m_next[int'(bus.wr_addr)] = int'(bus.wr_data) / (1 << OW);
            m_out[int'(bus.wr_addr)]  = int'(bus.wr_data) % (1 << OW);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(bus.state), m_state);
        check({tag, ".s"}, int'(bus.s), m_s);
        check({tag, ".mark"}, int'(bus.mark), m_mark);
        check({tag, ".cnt"}, int'(bus.cycle_cnt), m_cnt);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit rst, input int a);
        bus.en      = en;
        bus.restart = rst;
        bus.a       = CW'(a);
        bus.wr_en   = 1'b0;
    endtask

    task automatic program_entry(input int a, input int st, input int nxt, input int out);
        drive(1'b0, 1'b0, 0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = (SW + CW)'(a * (1 << SW) + st);
        bus.wr_data = (SW + OW)'(nxt * (1 << OW) + out);
        step("prog");
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int seq_a0 [6];
        int seq_a1 [5];
        tests = 0;
        fails = 0;
        seq_a0 = '{2, 5, 6, 4, 2, 5};
        seq_a1 = '{3, 6, 4, 2, 5};

        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        bus.a       = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        model_reset();

        // Reset asserted at t=1, checked while held
        #1 reset = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Blank table: machine parks at START
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step("blank");
        drive(1'b1, 1'b0, 1);
        step("blank_a1");

        // Program the sample table
        for (int a = 0; a < 2; a++) begin
            program_entry(a, 0, 2, 2);
            program_entry(a, 2, 5, 5);
            program_entry(a, 3, 6, 6);
            program_entry(a, 6, 4, 4);
            program_entry(a, 4, 2, 2);
        end
        program_entry(0, 5, 6, 6);
        program_entry(1, 5, 3, 3);

        // a=0 loop
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            step("loop_a0");
            check("seq_a0", int'(bus.s), seq_a0[i]);
        end

        // a=1 from state 5 takes the branch through 3
        drive(1'b1, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            step("loop_a1");
            check("seq_a1", int'(bus.s), seq_a1[i]);
        end
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 2; i++) step("back_a0");
        check("back_a0_s", int'(bus.s), 4);

        // Walk to state 6, then hold
        for (int i = 0; i < 3; i++) step("to6");
        check("at6", int'(bus.state), 6);
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step("hold");
            check("hold_s", int'(bus.s), 6);
        end
        drive(1'b1, 1'b0, 0);
        step("resume");
        check("resume_s", int'(bus.s), 4);

        // Restart wins over en
        drive(1'b1, 1'b1, 0);
        step("restart");
        check("restart_state", int'(bus.state), START);

        // Same-edge step and write: step uses the old entry
        drive(1'b1, 1'b0, 0);
        step("to2");
        check("in2", int'(bus.state), 2);
        bus.wr_en   = 1'b1;
        bus.wr_addr = (SW + CW)'(2);
        bus.wr_data = (SW + OW)'(1 * (1 << OW) + 7);
        step("wr_same");
        check("wr_same_s", int'(bus.s), 5);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 3; i++) step("revisit");
        check("revisit_state", int'(bus.state), 2);
        step("new_entry");
        check("new_entry_state", int'(bus.state), 1);
        check("new_entry_s", int'(bus.s), 7);
        step("unprog");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bus.en      = ($urandom_range(0, 3) != 0);
            bus.restart = ($urandom_range(0, 15) == 0);
            bus.a       = CW'($urandom_range(0, (1 << CW) - 1));
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_addr = (SW + CW)'($urandom_range(0, DEPTH - 1));
            bus.wr_data = (SW + OW)'($urandom_range(0, (1 << (SW + OW)) - 1));
            step("rand");
        end

        // Async reset in the middle of a cycle
        drive(1'b1, 1'b0, 0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 2; a++) begin
            drive(1'b1, 1'b0, a);
            step("after_reset");
            check("cleared_state", int'(bus.state), START);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
